// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a 2-flop input synchronizer and mid-bit sampling.
// Latency: o_Rx_DV/o_Rx_Frame_Err pulse on the clock after the stop-bit sample; no backpressure (take the byte on the pulse).
// Build option: define UART_RX_MAJORITY_EN for 2-of-3 majority voting around every sample point.
module uart_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       i_Rst_n,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Rx_Active,
    output logic       o_Rx_Frame_Err
);

    localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF     = 16'((CLKS_PER_BIT - 1) / 2);

    // With voting the start decision moves one clock later; every later sample
    // point inherits that shift, so data/stop keep the same BIT_LAST terminal
    // count and land on mid+1 of their bit without any drift.
`ifdef UART_RX_MAJORITY_EN
    localparam logic [15:0] START_LAST = HALF + 16'd1;
`else
    localparam logic [15:0] START_LAST = HALF;
`endif

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4,
        CLEANUP   = 3'd5
    } state_t;

    state_t      state, nxt_state;
    logic        rx_meta;
    logic        rx_s;
    logic [15:0] clk_cnt, nxt_clk_cnt;
    logic [2:0]  bit_idx, nxt_bit_idx;
    logic [7:0]  shift_dat, nxt_shift_dat;
    logic [7:0]  nxt_byte;
    logic        nxt_dv;
    logic        nxt_active;
    logic        nxt_frame_err;
    logic        sample_bit;

    always_ff @(posedge clk) begin
        if (!i_Rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_Rx_Serial;
            rx_s    <= rx_meta;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // rx_hist[0] is rx_s one clock ago, rx_hist[1] two clocks ago.
    logic [1:0] rx_hist;

    always_ff @(posedge clk) begin
        if (!i_Rst_n) begin
            rx_hist <= 2'b11;
        end else begin
            rx_hist <= {rx_hist[0], rx_s};
        end
    end

    assign sample_bit = (rx_s & rx_hist[0]) | (rx_s & rx_hist[1]) | (rx_hist[0] & rx_hist[1]);
`else
    assign sample_bit = rx_s;
`endif

    always_ff @(posedge clk) begin
        if (!i_Rst_n) begin
            state          <= IDLE;
            clk_cnt        <= 16'd0;
            bit_idx        <= 3'd0;
            shift_dat      <= 8'h00;
            o_Rx_Byte      <= 8'h00;
            o_Rx_DV        <= 1'b0;
            o_Rx_Active    <= 1'b0;
            o_Rx_Frame_Err <= 1'b0;
        end else begin
            state          <= nxt_state;
            clk_cnt        <= nxt_clk_cnt;
            bit_idx        <= nxt_bit_idx;
            shift_dat      <= nxt_shift_dat;
            o_Rx_Byte      <= nxt_byte;
            o_Rx_DV        <= nxt_dv;
            o_Rx_Active    <= nxt_active;
            o_Rx_Frame_Err <= nxt_frame_err;
        end
    end

    always_comb begin
        nxt_state     = state;
        nxt_clk_cnt   = clk_cnt;
        nxt_bit_idx   = bit_idx;
        nxt_shift_dat = shift_dat;
        nxt_byte      = o_Rx_Byte;
        nxt_dv        = 1'b0;
        nxt_active    = o_Rx_Active;
        nxt_frame_err = 1'b0;

        case (state)
            IDLE: begin
                nxt_clk_cnt = 16'd0;
                nxt_bit_idx = 3'd0;
                if (!rx_s) begin
                    nxt_state = START;
                end
            end

            START: begin
                if (clk_cnt == START_LAST) begin
                    nxt_clk_cnt = 16'd0;
                    if (!sample_bit) begin
                        nxt_state  = DATA;
                        nxt_active = 1'b1;
                    end else begin
                        nxt_state = IDLE;
                    end
                end else begin
                    nxt_clk_cnt = clk_cnt + 16'd1;
                end
            end

            DATA: begin
                if (clk_cnt == BIT_LAST) begin
                    nxt_clk_cnt            = 16'd0;
                    nxt_shift_dat[bit_idx] = sample_bit;
                    if (bit_idx == 3'd7) begin
                        nxt_bit_idx = 3'd0;
                        nxt_state   = STOP;
                    end else begin
                        nxt_bit_idx = bit_idx + 3'd1;
                    end
                end else begin
                    nxt_clk_cnt = clk_cnt + 16'd1;
                end
            end

            STOP: begin
                if (clk_cnt == BIT_LAST) begin
                    nxt_clk_cnt = 16'd0;
                    nxt_active  = 1'b0;
                    if (sample_bit) begin
                        nxt_state = CLEANUP;
                        nxt_dv    = 1'b1;
                        nxt_byte  = shift_dat;
                    end else begin
                        nxt_state     = WAIT_HIGH;
                        nxt_frame_err = 1'b1;
                    end
                end else begin
                    nxt_clk_cnt = clk_cnt + 16'd1;
                end
            end

            // Line stuck low (break): hold off until it returns to idle level.
            WAIT_HIGH: begin
                nxt_clk_cnt = 16'd0;
                nxt_active  = 1'b0;
                if (rx_s) begin
                    nxt_state = CLEANUP;
                end
            end

            CLEANUP: begin
                nxt_clk_cnt = 16'd0;
                nxt_bit_idx = 3'd0;
                nxt_active  = 1'b0;
                nxt_state   = IDLE;
            end

            default: begin
                nxt_state   = IDLE;
                nxt_clk_cnt = 16'd0;
                nxt_bit_idx = 3'd0;
                nxt_active  = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning clocks per serial bit (50 MHz, 115200 baud); legal range 8..65535.
REQ-002 SHALL have port clk  input  1  the only clock; all logic on its rising edge.
REQ-003 SHALL have port i_Rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port i_Rx_Serial  input  1  asynchronous serial line; idles high.
REQ-005 SHALL have port o_Rx_DV  output  1  one-cycle pulse; o_Rx_Byte holds a valid received byte.
REQ-006 SHALL have port o_Rx_Byte  output  8  last good received byte, LSB received first.
REQ-007 SHALL have port o_Rx_Active  output  1  high while a frame is in progress.
REQ-008 SHALL have port o_Rx_Frame_Err  output  1  one-cycle pulse; stop bit sampled low.

Function
REQ-009 SHALL pass i_Rx_Serial through a 2-flop synchronizer; all decisions use the synchronized value (rx_s).
REQ-010 SHALL implement states IDLE, START, DATA, STOP, WAIT_HIGH, CLEANUP; an illegal encoding SHALL go to IDLE.
REQ-011 IDLE: clock counter and bit index held at 0; rx_s == 0 -> START, counter starts at 0.
REQ-012 START: count to (CLKS_PER_BIT-1)/2 (integer division); at that count, sampled 0 -> DATA with counter 0, and o_Rx_Active goes high; sampled 1 -> IDLE (false start, no outputs pulse).
REQ-013 DATA: count to CLKS_PER_BIT-1, sample bit into shift position r_Bit_Index (0..7, LSB first), reset counter; after index 7 -> STOP with index 0.
REQ-014 STOP: count to CLKS_PER_BIT-1 and sample; 1 -> CLEANUP with o_Rx_DV=1 and o_Rx_Byte updated in the same cycle; 0 -> WAIT_HIGH with o_Rx_Frame_Err=1 and o_Rx_Byte unchanged.
REQ-015 WAIT_HIGH: stay until rx_s == 1 (break condition); then -> CLEANUP.
REQ-016 CLEANUP: one cycle; o_Rx_Active low; -> IDLE.
REQ-017 o_Rx_DV and o_Rx_Frame_Err SHALL each be high exactly one cycle per frame, never both in the same frame.
REQ-018 o_Rx_Active SHALL deassert on entry to CLEANUP or WAIT_HIGH.
REQ-019 Clock counter SHALL be 16 bits and never wrap within a frame.
REQ-020 A new start edge SHALL be accepted at the first IDLE cycle after CLEANUP, supporting back-to-back frames with one stop bit.

Reset
REQ-021 i_Rst_n low at a clock edge SHALL force state IDLE, counter 0, index 0, synchronizer flops 1, o_Rx_Byte 0x00, o_Rx_DV 0, o_Rx_Active 0, o_Rx_Frame_Err 0.
REQ-022 Reset mid-frame SHALL abandon the frame with no DV or error pulse; reception resumes on the next falling edge after release.

Configuration
REQ-023 Macro UART_RX_MAJORITY_EN defined: each data/stop/start sample SHALL be the 2-of-3 majority of rx_s at counts mid-1, mid, mid+1 (mid = sample count of REQ-012/013/014), decision taken at mid+1.
REQ-024 Macro UART_RX_MAJORITY_EN undefined: single sample of rx_s at mid; no majority logic synthesized.

Verification
REQ-025 Reset low 5 cycles, then frame 0x55 at CLKS_PER_BIT=434 -> o_Rx_DV one cycle, o_Rx_Byte=0x55, o_Rx_Frame_Err stays 0.
REQ-026 Low glitch of 100 cycles on idle line -> return to IDLE, no DV, no error, o_Rx_Active stays 0.
REQ-027 Frame 0xA5 with stop bit driven 0, line held low 2000 cycles then high -> o_Rx_Frame_Err one cycle, no DV, o_Rx_Byte unchanged, next frame 0x3C received correctly.
REQ-028 Back-to-back frames 0xA5, 0x3C, 0xFF with one stop bit -> three DV pulses with bytes in that order.
REQ-029 i_Rst_n low during bit 4 of frame 0x0F, then frame 0x81 -> no pulse for 0x0F; DV with 0x81.
REQ-030 With UART_RX_MAJORITY_EN, one-cycle inverted glitch at mid-point of every data bit of 0x96 -> o_Rx_Byte=0x96; without the macro, the same stimulus -> o_Rx_Byte=0x69.
